// File: rtl/fetch_receive_ooo.sv
// Fetch receive queue: pairs issued PCs with in-order I-cache responses
// and tracks responses still owed for requests dropped by a redirect.
module fetch_receive_ooo #(
   parameter int XLEN       = 64,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_issue_valid,
   output logic                  fetch_issue_ready,
   input  logic [XLEN-1:0]       fetch_issue_PC,
   input  logic                  fetch_issue_NLP_BTB_hit,
   input  logic                  icache_response_valid,
   input  logic [INST_WIDTH-1:0] icache_response_instruction,
   input  logic                  flush,
   output logic                  decode_valid,
   input  logic                  decode_ready,
   output logic [XLEN-1:0]       decode_PC,
   output logic [INST_WIDTH-1:0] decode_instruction,
   output logic                  decode_NLP_BTB_hit
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

   logic [XLEN-1:0]       r_pc   [DEPTH];
   logic                  r_btb  [DEPTH];
   logic [INST_WIDTH-1:0] r_inst [DEPTH];
   logic [DEPTH-1:0]      r_ivld;

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_resp_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] r_pend;

   logic          w_issue;
   logic          w_decode;
   logic          w_drop_rsp;
   logic          w_fill;
   logic          w_dec_valid;
   logic [CW:0]   w_occ;
   logic [CW:0]   w_owed;
   logic [CW:0]   w_flush_drop;

   assign w_occ = {1'b0, r_count} + {1'b0, r_drop};
   assign fetch_issue_ready = (w_occ < L_DEPTH) && !flush;

   assign w_dec_valid = (r_count != '0) && r_ivld[r_rd_ptr] && !flush;
   assign w_issue     = fetch_issue_valid && fetch_issue_ready;
   assign w_decode    = w_dec_valid && decode_ready;
   assign w_drop_rsp  = icache_response_valid && (r_drop != '0);
   assign w_fill      = icache_response_valid && (r_drop == '0)
                        && (r_pend != '0) && !flush;

   // pend counts entries still waiting on the I-cache; a response in the
   // flush cycle settles one of the owed responses
   assign w_owed = {1'b0, r_drop} + {1'b0, r_pend};
   assign w_flush_drop = (icache_response_valid && (w_owed != '0))
                         ? w_owed - (CW+1)'(1) : w_owed;

   assign decode_valid       = w_dec_valid;
   assign decode_PC          = w_dec_valid ? r_pc[r_rd_ptr]   : '0;
   assign decode_instruction = w_dec_valid ? r_inst[r_rd_ptr] : '0;
   assign decode_NLP_BTB_hit = w_dec_valid ? r_btb[r_rd_ptr]  : 1'b0;

   always_ff @(posedge clock) begin
      if (w_issue) begin
         r_pc[r_wr_ptr]  <= fetch_issue_PC;
         r_btb[r_wr_ptr] <= fetch_issue_NLP_BTB_hit;
      end
      if (w_fill) begin
         r_inst[r_resp_ptr] <= icache_response_instruction;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_resp_ptr <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop     <= '0;
         r_pend     <= '0;
         r_ivld     <= '0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_resp_ptr <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pend     <= '0;
         r_ivld     <= '0;
         r_drop     <= w_flush_drop[CW-1:0];
      end else begin
         if (w_issue) begin
            r_wr_ptr         <= r_wr_ptr + PW'(1);
            r_ivld[r_wr_ptr] <= 1'b0;
         end
         if (w_fill) begin
            r_resp_ptr         <= r_resp_ptr + PW'(1);
            r_ivld[r_resp_ptr] <= 1'b1;
         end
         if (w_decode) begin
            r_rd_ptr         <= r_rd_ptr + PW'(1);
            r_ivld[r_rd_ptr] <= 1'b0;
         end
         if (w_issue && !w_decode) begin
            r_count <= r_count + CW'(1);
         end else if (!w_issue && w_decode) begin
            r_count <= r_count - CW'(1);
         end
         if (w_issue && !w_fill) begin
            r_pend <= r_pend + CW'(1);
         end else if (!w_issue && w_fill) begin
            r_pend <= r_pend - CW'(1);
         end
         if (w_drop_rsp) begin
            r_drop <= r_drop - CW'(1);
         end
      end
   end

endmodule
